// File: rtl/vram_arbiter.sv
// Shares one DRAM between a CPU port and a video fetch port, with periodic RAS-only refresh.
// Each access is one ROW cycle, TCAS COL cycles and TRP precharge cycles; refresh wins every grant.
module vram_arbiter #(
  parameter int unsigned TCAS       = 2,
  parameter int unsigned TRP        = 2,
  parameter int unsigned REF_PERIOD = 64
) (
  input  logic        pin_clk,
  input  logic        pin_rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [1:0]  cpu_be,
  input  logic [13:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  output logic        cpu_ack,
  input  logic        vid_req,
  input  logic [13:0] vid_addr,
  output logic [15:0] vid_rdata,
  output logic        vid_ack,
  output logic [6:0]  ma,
  output logic        ras_n,
  output logic [1:0]  cas_n,
  output logic        we_n,
  output logic [15:0] dram_di,
  input  logic [15:0] dram_do
);

  typedef enum logic [2:0] {StIdle, StRow, StCol, StPre, StRef} state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [9:0]  timer_q;
  logic        pend_q;
  logic [6:0]  ref_row_q;
  logic [1:0]  starve_q;
  logic [13:0] addr_q;
  logic        we_q;
  logic [1:0]  be_q;
  logic [15:0] wdata_q;
  logic        is_vid_q;
  logic        cpu_ack_q, vid_ack_q;
  logic [15:0] cpu_rdata_q, vid_rdata_q;

  logic timer_wrap, refresh_req, cpu_starved, cpu_write;
  logic grant_ref, grant_vid, grant_cpu;
  logic col_done, ref_done;

  assign timer_wrap  = (timer_q == 10'(REF_PERIOD - 1));
  // A wrap in the IDLE cycle itself counts as pending so refresh beats a same-cycle request.
  assign refresh_req = pend_q | timer_wrap;
  assign cpu_starved = cpu_req & (starve_q == 2'd2);
  assign cpu_write   = ~is_vid_q & we_q;
  assign col_done    = (state_q == StCol) && (cnt_q == 3'(TCAS - 1));
  assign ref_done    = (state_q == StRef) && (cnt_q == 3'(TCAS));

  always_comb begin
    grant_ref = 1'b0;
    grant_vid = 1'b0;
    grant_cpu = 1'b0;
    if (state_q == StIdle) begin
      if (refresh_req)                  grant_ref = 1'b1;
      else if (vid_req && !cpu_starved) grant_vid = 1'b1;
      else if (cpu_req)                 grant_cpu = 1'b1;
    end
  end

  always_ff @(posedge pin_clk) begin
    if (pin_rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (grant_ref)                   state_d = StRef;
        else if (grant_vid || grant_cpu) state_d = StRow;
      end
      StRow: begin
        state_d = StCol;
        cnt_d   = '0;
      end
      StCol: begin
        if (col_done) begin
          state_d = StPre;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      StRef: begin
        if (ref_done) begin
          state_d = StPre;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      StPre: begin
        if (cnt_q == 3'(TRP - 1)) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ras_n = 1'b1;
    cas_n = 2'b11;
    we_n  = 1'b1;
    ma    = '0;
    unique case (state_q)
      StRow: begin
        ras_n = 1'b0;
        ma    = addr_q[13:7];
      end
      StCol: begin
        ras_n = 1'b0;
        ma    = addr_q[6:0];
        cas_n = cpu_write ? ~be_q : 2'b00;
        we_n  = ~cpu_write;
      end
      StRef: begin
        ras_n = 1'b0;
        ma    = ref_row_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge pin_clk) begin
    if (pin_rst) begin
      timer_q     <= '0;
      pend_q      <= 1'b0;
      ref_row_q   <= '0;
      starve_q    <= '0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      be_q        <= '0;
      wdata_q     <= '0;
      is_vid_q    <= 1'b0;
      cpu_ack_q   <= 1'b0;
      vid_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      vid_rdata_q <= '0;
    end else begin
      timer_q <= timer_wrap ? '0 : timer_q + 10'd1;
      // A wrap while refresh is already pending is dropped.
      if (ref_done)        pend_q <= 1'b0;
      else if (timer_wrap) pend_q <= 1'b1;
      if (ref_done) ref_row_q <= ref_row_q + 7'd1;
      if (grant_cpu)      starve_q <= '0;
      else if (grant_vid) starve_q <= cpu_req ? starve_q + 2'd1 : '0;
      if (grant_vid) begin
        addr_q   <= vid_addr;
        we_q     <= 1'b0;
        is_vid_q <= 1'b1;
      end
      if (grant_cpu) begin
        addr_q   <= cpu_addr;
        we_q     <= cpu_we;
        be_q     <= cpu_be;
        wdata_q  <= cpu_wdata;
        is_vid_q <= 1'b0;
      end
      cpu_ack_q <= col_done & ~is_vid_q;
      vid_ack_q <= col_done & is_vid_q;
      if (col_done && is_vid_q)            vid_rdata_q <= dram_do;
      if (col_done && !is_vid_q && !we_q)  cpu_rdata_q <= dram_do;
    end
  end

  assign cpu_ack   = cpu_ack_q;
  assign vid_ack   = vid_ack_q;
  assign cpu_rdata = cpu_rdata_q;
  assign vid_rdata = vid_rdata_q;
  assign dram_di   = wdata_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: directed scenarios plus randomized traffic, all cycles checked
// against a timeline-based reference model; a second instance exercises a short refresh period.
module tb_vram_arbiter;

  localparam int TCAS_T = 2;
  localparam int TRP_T  = 2;
  localparam int P_MAIN = 64;
  localparam int P_REF  = 8;
  localparam int L      = 2 + TCAS_T + TRP_T;

  logic        pin_clk = 1'b0;
  logic        pin_rst;
  logic        cpu_req, cpu_we, vid_req;
  logic [1:0]  cpu_be;
  logic [13:0] cpu_addr, vid_addr;
  logic [15:0] cpu_wdata, dram_do;
  logic [15:0] cpu_rdata, vid_rdata, dram_di;
  logic        cpu_ack, vid_ack, ras_n, we_n;
  logic [1:0]  cas_n;
  logic [6:0]  ma;

  logic [15:0] r_cpu_rdata, r_vid_rdata, r_dram_di;
  logic        r_cpu_ack, r_vid_ack, r_ras_n, r_we_n;
  logic [1:0]  r_cas_n;
  logic [6:0]  r_ma;

  int checks   = 0;
  int failures = 0;

  always #5 pin_clk = ~pin_clk;

  vram_arbiter #(.TCAS(TCAS_T), .TRP(TRP_T), .REF_PERIOD(P_MAIN)) dut (
    .pin_clk(pin_clk), .pin_rst(pin_rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_be(cpu_be), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_rdata(vid_rdata), .vid_ack(vid_ack),
    .ma(ma), .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n), .dram_di(dram_di), .dram_do(dram_do)
  );

  vram_arbiter #(.TCAS(TCAS_T), .TRP(TRP_T), .REF_PERIOD(P_REF)) dut_r (
    .pin_clk(pin_clk), .pin_rst(pin_rst),
    .cpu_req(1'b0), .cpu_we(1'b0), .cpu_be(2'b00), .cpu_addr(14'h0000),
    .cpu_wdata(16'h0000), .cpu_rdata(r_cpu_rdata), .cpu_ack(r_cpu_ack),
    .vid_req(1'b0), .vid_addr(14'h0000), .vid_rdata(r_vid_rdata), .vid_ack(r_vid_ack),
    .ma(r_ma), .ras_n(r_ras_n), .cas_n(r_cas_n), .we_n(r_we_n), .dram_di(r_dram_di),
    .dram_do(16'h0000)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge pin_clk);
    #1;
  endtask

  task automatic step_n(input int k);
    for (int i = 0; i < k; i++) step();
  endtask

  task automatic do_reset();
    pin_rst = 1'b1;
    step();
    step();
    pin_rst = 1'b0;
  endtask

  task automatic wait_ack(input bit vid, input int budget, input string tag);
    int k = 0;
    while (((vid ? vid_ack : cpu_ack) !== 1'b1) && k < budget) begin
      step();
      k++;
    end
    chk(tag, 32'(k < budget), 1);
  endtask

  // Reference model: one transaction occupies L cycles after its grant; phase = cycles since grant.
  bit          m_valid = 0;
  bit          m_act, m_pend;
  int          m_n, m_g, m_kind, m_row, m_starve;
  logic [13:0] m_addr;
  logic        m_we;
  logic [1:0]  m_be;
  logic [15:0] m_wdata, m_cpu_rd, m_vid_rd;

  always @(negedge pin_clk) begin : model
    int         ph;
    logic       e_ras, e_we, e_ca, e_va;
    logic [1:0] e_cas;
    logic [6:0] e_ma;
    bit         wrap, end_ref, last_col;
    if (m_valid) begin
      if (m_act && (m_n - m_g) >= L) m_act = 0;
      ph    = m_n - m_g;
      e_ras = 1;
      e_cas = 2'b11;
      e_we  = 1;
      e_ma  = '0;
      e_ca  = 0;
      e_va  = 0;
      if (m_act) begin
        if (m_kind == 2) begin
          if (ph <= TCAS_T + 1) begin
            e_ras = 0;
            e_ma  = 7'(m_row);
          end
        end else if (ph == 1) begin
          e_ras = 0;
          e_ma  = m_addr[13:7];
        end else if (ph <= TCAS_T + 1) begin
          e_ras = 0;
          e_ma  = m_addr[6:0];
          if (m_kind == 0 && m_we) begin
            e_cas = ~m_be;
            e_we  = 0;
          end else begin
            e_cas = 2'b00;
          end
        end else if (ph == TCAS_T + 2) begin
          e_ca = (m_kind == 0);
          e_va = (m_kind == 1);
        end
      end
      chk("model_strobes", 32'({ras_n, cas_n, we_n, ma, cpu_ack, vid_ack}),
          32'({e_ras, e_cas, e_we, e_ma, e_ca, e_va}));
      chk("model_dram_di", 32'(dram_di), 32'(m_wdata));
      chk("model_cpu_rdata", 32'(cpu_rdata), 32'(m_cpu_rd));
      chk("model_vid_rdata", 32'(vid_rdata), 32'(m_vid_rd));

      wrap     = (m_n % P_MAIN) == P_MAIN - 1;
      end_ref  = m_act && m_kind == 2 && ph == TCAS_T + 1;
      last_col = m_act && m_kind != 2 && ph == TCAS_T + 1;
      if (last_col && m_kind == 0 && !m_we) m_cpu_rd = dram_do;
      if (last_col && m_kind == 1)          m_vid_rd = dram_do;
      if (end_ref) m_row = (m_row + 1) % 128;
      if (!m_act) begin
        if (m_pend || wrap) begin
          m_act = 1; m_g = m_n; m_kind = 2;
        end else if (vid_req && !(cpu_req && m_starve >= 2)) begin
          m_act = 1; m_g = m_n; m_kind = 1;
          m_addr = vid_addr; m_we = 0;
          m_starve = cpu_req ? m_starve + 1 : 0;
        end else if (cpu_req) begin
          m_act = 1; m_g = m_n; m_kind = 0;
          m_addr = cpu_addr; m_we = cpu_we; m_be = cpu_be; m_wdata = cpu_wdata;
          m_starve = 0;
        end
      end
      if (end_ref)   m_pend = 0;
      else if (wrap) m_pend = 1;
      m_n++;
    end
    if (pin_rst === 1'b1) begin
      m_valid = 1; m_act = 0; m_pend = 0; m_n = 0; m_row = 0; m_starve = 0;
      m_addr = '0; m_we = 0; m_be = '0; m_wdata = '0; m_cpu_rd = '0; m_vid_rd = '0;
    end
  end

  initial begin
    int   got[6];
    int   exp_order[6];
    int   n, k, last, row_exp, low_run, refs;
    bit   cas_low;
    logic prev_ras;
    pin_rst = 0; cpu_req = 0; cpu_we = 0; cpu_be = 0; cpu_addr = 0; cpu_wdata = 0;
    vid_req = 0; vid_addr = 0; dram_do = 0;

    // CPU read timing and data
    do_reset();
    cpu_req = 1; cpu_we = 0; cpu_be = 2'b11; cpu_addr = 14'h0081; dram_do = 16'hA5C3;
    step();
    chk("rd_row_ma", 32'(ma), 'h01);
    chk("rd_row_ras", 32'(ras_n), 0);
    for (int i = 0; i < TCAS_T; i++) begin
      step();
      chk("rd_col_ma", 32'(ma), 'h01);
      chk("rd_col_cas", 32'(cas_n), 'b00);
      chk("rd_col_noack", 32'(cpu_ack), 0);
    end
    step();
    chk("rd_ack", 32'(cpu_ack), 1);
    chk("rd_data", 32'(cpu_rdata), 'hA5C3);
    cpu_req = 0; vid_req = 1; vid_addr = 14'h2A55;
    for (int i = 1; i < TRP_T; i++) begin
      step();
      chk("rd_pre_ras", 32'(ras_n), 1);
      chk("rd_pre_noack", 32'(cpu_ack), 0);
    end
    step();
    chk("rd_idle_ras", 32'(ras_n), 1);
    step();
    chk("rd_next_row", 32'({ras_n, ma}), 'h54);
    wait_ack(1, 20, "rd_vid_ack");
    vid_req = 0;
    step_n(L);

    // CPU high-byte write
    do_reset();
    cpu_req = 1; cpu_we = 1; cpu_be = 2'b10; cpu_wdata = 16'h1234; cpu_addr = 14'h1357;
    step();
    for (int i = 0; i < TCAS_T; i++) begin
      step();
      chk("wr_cas", 32'(cas_n), 'b01);
      chk("wr_we", 32'(we_n), 0);
      chk("wr_di", 32'(dram_di), 'h1234);
      chk("wr_col_noack", 32'(cpu_ack), 0);
    end
    step();
    chk("wr_ack", 32'(cpu_ack), 1);
    chk("wr_pre_we", 32'(we_n), 1);
    cpu_req = 0;
    step();
    chk("wr_single_ack", 32'(cpu_ack), 0);
    step_n(L);

    // Starvation guard: both held continuously
    do_reset();
    exp_order = '{1, 1, 0, 1, 1, 0};
    for (int i = 0; i < 6; i++) got[i] = 2;
    cpu_req = 1; cpu_we = 0; cpu_addr = 14'h0123; vid_req = 1; vid_addr = 14'h0456;
    n = 0; k = 0;
    while (n < 6 && k < 200) begin
      step();
      k++;
      if (vid_ack === 1'b1) begin
        got[n] = 1; n++;
      end else if (cpu_ack === 1'b1) begin
        got[n] = 0; n++;
      end
    end
    cpu_req = 0; vid_req = 0;
    chk("fair_count", n, 6);
    for (int i = 0; i < 6; i++) chk($sformatf("fair_order%0d", i), got[i], exp_order[i]);
    step_n(L);

    // Refresh wrap in IDLE beats a simultaneous video request
    do_reset();
    step_n(P_MAIN - 1);
    vid_req = 1; vid_addr = 14'h3F80;
    step();
    chk("refvid_ref_first", 32'({ras_n, ma, cas_n}), 'h003);
    step_n(TCAS_T + TRP_T + 2);
    chk("refvid_vid_next", 32'({ras_n, ma}), 'h7F);
    wait_ack(1, 20, "refvid_vid_ack");
    vid_req = 0;
    step_n(L);

    // Reset mid-COL of a write, then reissue
    do_reset();
    cpu_req = 1; cpu_we = 1; cpu_be = 2'b11; cpu_wdata = 16'hBEEF; cpu_addr = 14'h0F0F;
    step();
    step();
    chk("rst_in_col", 32'(we_n), 0);
    pin_rst = 1;
    step();
    chk("rst_idle_strobes", 32'({ras_n, cas_n, we_n}), 'hF);
    chk("rst_no_ack", 32'(cpu_ack), 0);
    chk("rst_ma_di", 32'({ma, dram_di}), 0);
    pin_rst = 0;
    step();
    chk("rst_reissue_row", 32'({ras_n, ma}), 'h1E);
    chk("rst_reissue_noack", 32'(cpu_ack), 0);
    wait_ack(0, 20, "rst_reissue_ack");
    chk("rst_reissue_di", 32'(dram_di), 'hBEEF);
    cpu_req = 0;
    step_n(L);

    // Short-period refresh on the second instance, through a row-counter wrap
    do_reset();
    last = -1; row_exp = 0; low_run = 0; refs = 0; cas_low = 0; prev_ras = 1;
    for (int cyc = 0; cyc < 131 * P_REF; cyc++) begin
      if (r_cas_n !== 2'b11) cas_low = 1;
      if (r_ras_n === 1'b0 && prev_ras === 1'b1) begin
        chk("refr_row", 32'(r_ma), 32'(row_exp));
        row_exp = (row_exp + 1) % 128;
        if (last >= 0) chk("refr_period", cyc - last, P_REF);
        else           chk("refr_first", cyc, P_REF);
        last = cyc;
        refs++;
      end
      if (r_ras_n === 1'b1 && prev_ras === 1'b0) chk("refr_len", low_run, TCAS_T + 1);
      low_run  = (r_ras_n === 1'b0) ? low_run + 1 : 0;
      prev_ras = r_ras_n;
      step();
    end
    chk("refr_cas_high", 32'(cas_low), 0);
    chk("refr_count", 32'(refs >= 130), 1);

    // Randomized traffic, occasional resets
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (cpu_req) begin
        if (cpu_ack === 1'b1 || $urandom_range(63) == 0) cpu_req = 0;
      end else if ($urandom_range(3) == 0) begin
        cpu_req = 1; cpu_we = 1'($urandom_range(1)); cpu_be = 2'($urandom_range(3));
        cpu_addr = 14'($urandom); cpu_wdata = 16'($urandom);
      end
      if (vid_req) begin
        if (vid_ack === 1'b1 || $urandom_range(63) == 0) vid_req = 0;
      end else if ($urandom_range(2) == 0) begin
        vid_req = 1; vid_addr = 14'($urandom);
      end
      dram_do = 16'($urandom);
      pin_rst = ($urandom_range(499) == 0);
      step();
    end
    pin_rst = 0; cpu_req = 0; vid_req = 0;
    step_n(L);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 SHALL have parameter TCAS, default 2: CAS-active cycles per access (1..7).
REQ-002 SHALL have parameter TRP, default 2: precharge cycles after every RAS cycle (1..7).
REQ-003 SHALL have parameter REF_PERIOD, default 64: cycles between refresh requests (8..1023).
REQ-004 SHALL have ports, in this order:
- pin_clk  in  1  sole clock; all logic on its rising edge.
- pin_rst  in  1  synchronous, active-high reset.
- cpu_req  in  1  CPU access request; level, held until cpu_ack.
- cpu_we  in  1  1 = write.
- cpu_be  in  2  byte enables [1]=high, [0]=low; ignored on read.
- cpu_addr  in  14  word address.
- cpu_wdata  in  16  write data.
- cpu_rdata  out  16  read data, valid with cpu_ack.
- cpu_ack  out  1  one-cycle completion pulse.
- vid_req  in  1  video fetch request; level, held until vid_ack.
- vid_addr  in  14  word address.
- vid_rdata  out  16  fetched word, valid with vid_ack.
- vid_ack  out  1  one-cycle completion pulse.
- ma  out  7  multiplexed DRAM address.
- ras_n  out  1  row strobe.
- cas_n  out  2  column strobes, [1]=high byte.
- we_n  out  1  write enable.
- dram_di  out  16  data to DRAM.
- dram_do  in  16  data from DRAM.

Function
REQ-005 SHALL use states IDLE, ROW, COL, PRE, REF.
REQ-006 SHALL split the address as row = addr[13:7], column = addr[6:0].
REQ-007 SHALL resolve grants only in IDLE, one grant per IDLE cycle, with priority refresh-pending > video > CPU, except as REQ-008.
REQ-008 SHALL count consecutive video grants made while cpu_req was high; when the count reaches 2, the next IDLE SHALL grant CPU over video (refresh still first); count clears on any CPU grant.
REQ-009 SHALL latch the granted requester's address, we, be and wdata in the grant cycle and go to ROW.
REQ-010 SHALL drive ma = row and ras_n = 0 for 1 cycle in ROW, then go to COL.
REQ-011 SHALL hold ras_n = 0 and ma = column for TCAS cycles in COL.
REQ-012 SHALL assert both cas_n bits in COL for reads and video fetches.
REQ-013 SHALL, for a CPU write, assert cas_n[i] = ~be[i] in COL, hold we_n = 0 for all of COL, and drive dram_di = latched wdata.
REQ-014 SHALL, for a CPU write with be = 2'b00, still perform the full cycle with both cas_n high and still ack.
REQ-015 SHALL sample dram_do on the last COL cycle into the requester's rdata register and pulse that requester's ack on the following cycle, the first PRE cycle.
REQ-016 SHALL, for writes, pulse cpu_ack on the first PRE cycle.
REQ-017 SHALL leave rdata registers unchanged at all other times.
REQ-018 SHALL drive ras_n, cas_n and we_n high for TRP cycles in PRE, then go to IDLE; no back-to-back RAS without PRE.
REQ-019 SHALL run a free-running refresh timer that wraps at REF_PERIOD-1 and sets refresh-pending on wrap.
REQ-020 SHALL, on a refresh grant, enter REF: ras_n = 0, ma = refresh row counter, cas_n high, for TCAS+1 cycles; then increment the counter mod 128, clear pending, go to PRE.
REQ-021 SHALL make a timer wrap during a busy cycle wait; a second wrap while pending is lost (single flag).
REQ-022 SHALL make a requester deasserting req before grant simply lose the request; a deassert after grant does not abort the cycle.
REQ-023 SHALL pulse each ack for exactly one cycle per granted access; never both acks in one cycle.

Reset
REQ-024 SHALL, on pin_rst high at a clock edge, go to IDLE, abort any cycle in progress, and set ras_n = 1, cas_n = 2'b11, we_n = 1, ma = 0, dram_di = 0, acks = 0, rdata = 0, refresh timer = 0, refresh row = 0, pending = 0, starvation count = 0.
REQ-025 SHALL make the first grant possible on the first edge after pin_rst falls.

Verification
REQ-026 SHALL verify a CPU read of addr 14'h0081 with dram_do = 16'hA5C3: ma = 7'h01 in ROW then 7'h01 in COL; cpu_rdata = 16'hA5C3 with cpu_ack exactly 1+1+TCAS cycles after grant; total idle-to-idle 1+1+TCAS+TRP.
REQ-027 SHALL verify a CPU write with be = 2'b10, wdata = 16'h1234: cas_n = 2'b01 and we_n = 0 throughout COL; dram_di = 16'h1234; single cpu_ack.
REQ-028 SHALL verify cpu_req and vid_req held continuously: grant order V, V, C, V, V, C, with no CPU wait longer than two video cycles.
REQ-029 SHALL verify refresh with no requests: REF_PERIOD = 8 gives a REF cycle every 8 cycles with ma = 0, 1, 2, ...; the row wraps 127 -> 0; cas_n is never low.
REQ-030 SHALL verify a timer wrap simultaneous with vid_req in IDLE: REF is granted first, video next.
REQ-031 SHALL verify pin_rst asserted mid-COL of a write: next cycle shows IDLE, all strobes high, no cpu_ack; a reissued request completes normally.
